// File: rtl/f2h_uart_tx_master_if.sv
// AXI3 single-beat bus between the UART transmit master and the HPS f2h slave port.
// The master modport drives addresses, write data and all valids/readies it owns.
interface f2h_uart_tx_master_if;
  logic [7:0]  m_awid;
  logic [31:0] m_awaddr;
  logic [3:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst;
  logic [1:0]  m_awlock;
  logic [3:0]  m_awcache;
  logic [2:0]  m_awprot;
  logic [4:0]  m_awuser;
  logic        m_awvalid;
  logic        m_awready;

  logic [7:0]  m_wid;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wlast;
  logic        m_wvalid;
  logic        m_wready;

  logic [7:0]  m_bid;
  logic [1:0]  m_bresp;
  logic        m_bvalid;
  logic        m_bready;

  logic [7:0]  m_arid;
  logic [31:0] m_araddr;
  logic [3:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic [1:0]  m_arlock;
  logic [3:0]  m_arcache;
  logic [2:0]  m_arprot;
  logic [4:0]  m_aruser;
  logic        m_arvalid;
  logic        m_arready;

  logic [7:0]  m_rid;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;
  logic        m_rvalid;
  logic        m_rready;

  modport master (
    output m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awlock, m_awcache, m_awprot, m_awuser, m_awvalid,
    input  m_awready,
    output m_wid, m_wdata, m_wstrb, m_wlast, m_wvalid,
    input  m_wready,
    input  m_bid, m_bresp, m_bvalid,
    output m_bready,
    output m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot, m_aruser, m_arvalid,
    input  m_arready,
    input  m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
    output m_rready
  );

  modport slave (
    input  m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awlock, m_awcache, m_awprot, m_awuser, m_awvalid,
    output m_awready,
    input  m_wid, m_wdata, m_wstrb, m_wlast, m_wvalid,
    output m_wready,
    output m_bid, m_bresp, m_bvalid,
    input  m_bready,
    input  m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot, m_aruser, m_arvalid,
    output m_arready,
    output m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
    input  m_rready
  );
endinterface

// File: rtl/f2h_uart_tx_master.sv
// Streams bytes to HPS UART0 over the f2h AXI3 port: poll LSR until THRE is set, then write THR.
// One outstanding transaction at a time; every AXI output comes straight from a register or a constant.
module f2h_uart_tx_master #(
  parameter logic [31:0] UART_BASE  = 32'hFFC02000,
  parameter logic [31:0] LSR_OFFSET = 32'h14,
  parameter logic [7:0]  AXI_ID     = 8'h00,
  parameter int unsigned POLL_GAP   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        busy,
  output logic        err,
  output logic [7:0]  err_cnt,
  f2h_uart_tx_master_if.master axi
);
  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_GAP, S_AW, S_B} state_t;

  localparam logic [15:0] GAP_LOAD = 16'(POLL_GAP);

  state_t      state_reg, state_next;
  logic [15:0] gap_cnt_reg;
  logic [7:0]  byte_reg;
  logic        tx_ready_reg, arvalid_reg, rready_reg, awvalid_reg, wvalid_reg, bready_reg;
  logic        aw_done_reg, w_done_reg;
  logic        err_reg;
  logic [7:0]  err_cnt_reg;

  logic accept, ar_hs, r_hs, aw_hs, w_hs, b_hs, aw_all, w_all, err_fire;

  assign accept   = tx_valid & tx_ready_reg;
  assign ar_hs    = arvalid_reg & axi.m_arready;
  assign r_hs     = rready_reg & axi.m_rvalid;
  assign aw_hs    = awvalid_reg & axi.m_awready;
  assign w_hs     = wvalid_reg & axi.m_wready;
  assign b_hs     = bready_reg & axi.m_bvalid;
  assign aw_all   = aw_done_reg | aw_hs;
  assign w_all    = w_done_reg | w_hs;
  assign err_fire = (r_hs & (axi.m_rresp != 2'b00)) | (b_hs & (axi.m_bresp != 2'b00));

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (accept) state_next = S_AR;
      S_AR:   if (ar_hs) state_next = S_R;
      S_R: begin
        if (r_hs) begin
          if (axi.m_rresp != 2'b00) state_next = S_IDLE;
          else if (axi.m_rdata[5])  state_next = S_AW;
          else                      state_next = S_GAP;
        end
      end
      S_GAP:  if (gap_cnt_reg <= 16'd1) state_next = S_AR;
      S_AW:   if (aw_all && w_all) state_next = S_B;
      S_B:    if (b_hs) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from state_next so each valid/ready is aligned with the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_ready_reg <= 1'b0;
      arvalid_reg  <= 1'b0;
      rready_reg   <= 1'b0;
      awvalid_reg  <= 1'b0;
      wvalid_reg   <= 1'b0;
      bready_reg   <= 1'b0;
      aw_done_reg  <= 1'b0;
      w_done_reg   <= 1'b0;
      gap_cnt_reg  <= 16'd0;
      byte_reg     <= 8'd0;
      err_reg      <= 1'b0;
      err_cnt_reg  <= 8'd0;
    end else begin
      tx_ready_reg <= (state_next == S_IDLE);
      arvalid_reg  <= (state_next == S_AR);
      rready_reg   <= (state_next == S_R);
      bready_reg   <= (state_next == S_B);
      if (accept) byte_reg <= tx_data;
      if (state_next == S_GAP)
        gap_cnt_reg <= (state_reg == S_GAP) ? gap_cnt_reg - 16'd1 : GAP_LOAD;
      if (state_reg != S_AW && state_next == S_AW) begin
        awvalid_reg <= 1'b1;
        wvalid_reg  <= 1'b1;
        aw_done_reg <= 1'b0;
        w_done_reg  <= 1'b0;
      end else if (state_reg == S_AW) begin
        // AW and W complete independently; each valid drops right after its own beat.
        if (aw_hs) begin
          awvalid_reg <= 1'b0;
          aw_done_reg <= 1'b1;
        end
        if (w_hs) begin
          wvalid_reg <= 1'b0;
          w_done_reg <= 1'b1;
        end
      end
      err_reg <= err_fire;
      if (err_fire && err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign tx_ready = tx_ready_reg;
  assign busy     = (state_reg != S_IDLE);
  assign err      = err_reg;
  assign err_cnt  = err_cnt_reg;

  assign axi.m_arid    = AXI_ID;
  assign axi.m_araddr  = UART_BASE + LSR_OFFSET;
  assign axi.m_arlen   = 4'd0;
  assign axi.m_arsize  = 3'b010;
  assign axi.m_arburst = 2'b01;
  assign axi.m_arlock  = 2'b00;
  assign axi.m_arcache = 4'd0;
  assign axi.m_arprot  = 3'd0;
  assign axi.m_aruser  = 5'd0;
  assign axi.m_arvalid = arvalid_reg;
  assign axi.m_rready  = rready_reg;

  assign axi.m_awid    = AXI_ID;
  assign axi.m_awaddr  = UART_BASE;
  assign axi.m_awlen   = 4'd0;
  assign axi.m_awsize  = 3'b010;
  assign axi.m_awburst = 2'b01;
  assign axi.m_awlock  = 2'b00;
  assign axi.m_awcache = 4'd0;
  assign axi.m_awprot  = 3'd0;
  assign axi.m_awuser  = 5'd0;
  assign axi.m_awvalid = awvalid_reg;

  assign axi.m_wid     = AXI_ID;
  assign axi.m_wdata   = {24'h0, byte_reg};
  assign axi.m_wstrb   = 4'b0001;
  assign axi.m_wlast   = 1'b1;
  assign axi.m_wvalid  = wvalid_reg;
  assign axi.m_bready  = bready_reg;

  logic unused_inputs;
  assign unused_inputs = ^{axi.m_bid, axi.m_rid, axi.m_rlast, axi.m_rdata[31:6], axi.m_rdata[4:0]};
endmodule

// File: tb/tb_f2h_uart_tx_master.sv
// Directed bench: a table of single-byte transactions against a small AXI slave model,
// followed by hand-written sequences for stalls, back-to-back traffic, resets and err_cnt saturation.
module tb_f2h_uart_tx_master;
  localparam int POLL_GAP = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'd0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, err;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  f2h_uart_tx_master_if axi();

  f2h_uart_tx_master #(.POLL_GAP(POLL_GAP)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .err(err), .err_cnt(err_cnt), .axi(axi)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Slave model configuration and observation log
  int         ar_lat = 0, aw_lat = 0, w_lat = 0, r_lat = 0, b_lat = 0;
  bit         rand_mode = 1'b0;
  int         lsr_busy = 0;
  logic [1:0] rresp_cfg = 2'b00, bresp_cfg = 2'b00;
  int         ar_count = 0, aw_count = 0, w_count = 0, err_seen = 0;
  int         stab_err = 0, const_err = 0, err_ready_bad = 0;
  logic [31:0] wq[$];
  int         gap_runs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic int pick(input int lat);
    return rand_mode ? int'($urandom_range(0, 3)) : lat;
  endfunction

  task automatic clear_log();
    ar_count = 0; aw_count = 0; w_count = 0; err_seen = 0;
    wq.delete();
    gap_runs.delete();
  endtask

  // AXI slave: everything happens on the falling edge; a handshake is recognised one half-cycle after it occurred.
  initial begin : slave
    bit ar_hs, aw_hs, w_hs, r_hs, b_hs;
    bit ar_act, aw_act, w_act, r_act, b_act, rd_pend, b_pend, aw_got, w_got;
    int ar_c, aw_c, w_c, r_c, b_c, ar_t, aw_t, w_t, r_t, b_t, run;
    logic p_arvalid, p_awvalid, p_wvalid, p_rready, p_bready;
    logic [31:0] p_araddr, p_awaddr, p_wdata;
    axi.m_arready = 0; axi.m_awready = 0; axi.m_wready = 0;
    axi.m_rvalid = 0; axi.m_rdata = 0; axi.m_rresp = 0; axi.m_rlast = 1; axi.m_rid = 0;
    axi.m_bvalid = 0; axi.m_bresp = 0; axi.m_bid = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        axi.m_arready = 0; axi.m_awready = 0; axi.m_wready = 0; axi.m_rvalid = 0; axi.m_bvalid = 0;
        ar_act = 0; aw_act = 0; w_act = 0; r_act = 0; b_act = 0;
        rd_pend = 0; b_pend = 0; aw_got = 0; w_got = 0; run = 0;
        p_arvalid = 0; p_awvalid = 0; p_wvalid = 0; p_rready = 0; p_bready = 0;
        p_araddr = 0; p_awaddr = 0; p_wdata = 0;
        continue;
      end
      ar_hs = p_arvalid && axi.m_arready;
      aw_hs = p_awvalid && axi.m_awready;
      w_hs  = p_wvalid && axi.m_wready;
      r_hs  = axi.m_rvalid && p_rready;
      b_hs  = axi.m_bvalid && p_bready;

      if (p_arvalid && !ar_hs && (!axi.m_arvalid || axi.m_araddr !== p_araddr)) stab_err++;
      if (p_awvalid && !aw_hs && (!axi.m_awvalid || axi.m_awaddr !== p_awaddr)) stab_err++;
      if (p_wvalid && !w_hs && (!axi.m_wvalid || axi.m_wdata !== p_wdata)) stab_err++;
      if ((ar_hs && axi.m_arvalid) || (aw_hs && axi.m_awvalid) || (w_hs && axi.m_wvalid)) stab_err++;

      if (ar_hs) begin
        ar_count++;
        if (p_araddr !== 32'hFFC02014 || axi.m_arlen !== 4'd0 || axi.m_arsize !== 3'd2 ||
            axi.m_arburst !== 2'b01 || axi.m_arid !== 8'h00) const_err++;
        axi.m_arready = 0; ar_act = 0; rd_pend = 1;
      end
      if (aw_hs) begin
        aw_count++;
        if (p_awaddr !== 32'hFFC02000 || axi.m_awlen !== 4'd0 || axi.m_awsize !== 3'd2 ||
            axi.m_awburst !== 2'b01 || axi.m_awid !== 8'h00 || axi.m_awlock !== 2'b00 ||
            axi.m_awcache !== 4'd0 || axi.m_awprot !== 3'd0 || axi.m_awuser !== 5'd0) const_err++;
        axi.m_awready = 0; aw_act = 0; aw_got = 1;
      end
      if (w_hs) begin
        w_count++;
        if (axi.m_wstrb !== 4'b0001 || axi.m_wlast !== 1'b1 || axi.m_wid !== 8'h00) const_err++;
        wq.push_back(p_wdata);
        axi.m_wready = 0; w_act = 0; w_got = 1;
      end
      if (aw_got && w_got) begin
        b_pend = 1; aw_got = 0; w_got = 0;
      end
      if (r_hs) axi.m_rvalid = 0;
      if (b_hs) axi.m_bvalid = 0;

      if (axi.m_arvalid && !axi.m_arready) begin
        if (!ar_act) begin ar_act = 1; ar_c = 0; ar_t = pick(ar_lat); end
        if (ar_c >= ar_t) axi.m_arready = 1; else ar_c++;
      end
      if (axi.m_awvalid && !axi.m_awready && !aw_got) begin
        if (!aw_act) begin aw_act = 1; aw_c = 0; aw_t = pick(aw_lat); end
        if (aw_c >= aw_t) axi.m_awready = 1; else aw_c++;
      end
      if (axi.m_wvalid && !axi.m_wready && !w_got) begin
        if (!w_act) begin w_act = 1; w_c = 0; w_t = pick(w_lat); end
        if (w_c >= w_t) axi.m_wready = 1; else w_c++;
      end
      if (rd_pend && !axi.m_rvalid) begin
        if (!r_act) begin r_act = 1; r_c = 0; r_t = pick(r_lat); end
        if (r_c >= r_t) begin
          axi.m_rvalid = 1; axi.m_rresp = rresp_cfg; rd_pend = 0; r_act = 0;
          if (rand_mode) axi.m_rdata = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFDF : 32'h20;
          else if (lsr_busy > 0) begin axi.m_rdata = 32'hFFFFFFDF; lsr_busy--; end
          else axi.m_rdata = 32'h20;
        end else r_c++;
      end
      if (b_pend && !axi.m_bvalid) begin
        if (!b_act) begin b_act = 1; b_c = 0; b_t = pick(b_lat); end
        if (b_c >= b_t) begin
          axi.m_bvalid = 1; axi.m_bresp = bresp_cfg; b_pend = 0; b_act = 0;
        end else b_c++;
      end

      if (err) begin
        err_seen++;
        if (!tx_ready) err_ready_bad++;
      end
      // A polling gap is the stretch where the master is busy but drives no valid or ready at all
      if (busy && !axi.m_arvalid && !axi.m_rready && !axi.m_awvalid && !axi.m_wvalid && !axi.m_bready) run++;
      else if (run > 0) begin gap_runs.push_back(run); run = 0; end

      p_arvalid = axi.m_arvalid; p_awvalid = axi.m_awvalid; p_wvalid = axi.m_wvalid;
      p_rready = axi.m_rready; p_bready = axi.m_bready;
      p_araddr = axi.m_araddr; p_awaddr = axi.m_awaddr; p_wdata = axi.m_wdata;
    end
  end

  // Called on a falling edge; returns on the falling edge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    tx_data = b;
    tx_valid = 1'b1;
    while (!tx_ready && n < 2000) begin @(negedge clk); n++; end
    check($sformatf("accept_timeout_%02h", b), n >= 2000, 1'b0);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(output int busy_bad);
    int n;
    n = 0;
    busy_bad = 0;
    while (!tx_ready && n < 2000) begin
      if (!busy) busy_bad++;
      @(negedge clk);
      n++;
    end
    check("idle_timeout", n >= 2000, 1'b0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  data;
    int          lsr_busy;
    logic [1:0]  rresp;
    logic [1:0]  bresp;
    int          aw_lat;
    int          w_lat;
    int          exp_ar;
    int          exp_aw;
    logic [31:0] exp_wdata;
    int          exp_err;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs[8];

  initial begin : main
    int busy_bad, bad, n;
    vecs[0] = '{8'h41, 0, 2'b00, 2'b00, 0, 0, 1, 1, 32'h00000041, 0, 8'd0};
    vecs[1] = '{8'h5A, 3, 2'b00, 2'b00, 0, 0, 4, 1, 32'h0000005A, 0, 8'd0};
    vecs[2] = '{8'h13, 0, 2'b00, 2'b00, 3, 0, 1, 1, 32'h00000013, 0, 8'd0};
    vecs[3] = '{8'hC7, 0, 2'b00, 2'b00, 0, 3, 1, 1, 32'h000000C7, 0, 8'd0};
    vecs[4] = '{8'h99, 0, 2'b00, 2'b00, 2, 2, 1, 1, 32'h00000099, 0, 8'd0};
    vecs[5] = '{8'h66, 0, 2'b10, 2'b00, 0, 0, 1, 0, 32'h00000000, 1, 8'd1};
    vecs[6] = '{8'h3C, 0, 2'b00, 2'b10, 0, 0, 1, 1, 32'h0000003C, 1, 8'd2};
    vecs[7] = '{8'hFF, 1, 2'b00, 2'b00, 1, 0, 2, 1, 32'h000000FF, 0, 8'd2};

    repeat (3) @(negedge clk);
    check("rst_tx_ready", tx_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_err_cnt", err_cnt, 8'd0);
    check("rst_valids", {axi.m_arvalid, axi.m_awvalid, axi.m_wvalid, axi.m_rready, axi.m_bready}, 5'd0);
    @(posedge clk); #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_tx_ready", tx_ready, 1'b1);

    for (int i = 0; i < 8; i++) begin
      clear_log();
      lsr_busy = vecs[i].lsr_busy; rresp_cfg = vecs[i].rresp; bresp_cfg = vecs[i].bresp;
      aw_lat = vecs[i].aw_lat; w_lat = vecs[i].w_lat;
      send_byte(vecs[i].data);
      wait_idle(busy_bad);
      repeat (3) @(negedge clk);
      $display("vec %0d: byte=%02h reads=%0d writes=%0d errs=%0d err_cnt=%0d",
               i, vecs[i].data, ar_count, aw_count, err_seen, err_cnt);
      check($sformatf("v%0d_ar", i), ar_count, vecs[i].exp_ar);
      check($sformatf("v%0d_aw", i), aw_count, vecs[i].exp_aw);
      check($sformatf("v%0d_w", i), w_count, vecs[i].exp_aw);
      if (vecs[i].exp_aw != 0) check($sformatf("v%0d_wdata", i), wq[0], vecs[i].exp_wdata);
      check($sformatf("v%0d_err", i), err_seen, vecs[i].exp_err);
      check($sformatf("v%0d_err_cnt", i), err_cnt, vecs[i].exp_cnt);
      check($sformatf("v%0d_gaps", i), gap_runs.size(), vecs[i].lsr_busy);
      bad = 0;
      foreach (gap_runs[k]) if (gap_runs[k] != POLL_GAP) bad++;
      check($sformatf("v%0d_gap_len", i), bad, 0);
      check($sformatf("v%0d_busy", i), busy_bad, 0);
    end
    rresp_cfg = 2'b00; bresp_cfg = 2'b00; aw_lat = 0; w_lat = 0;

    // Back-to-back stream with random stalls and random THRE
    clear_log();
    rand_mode = 1'b1;
    for (int b = 0; b < 256; b++) send_byte(8'(b));
    wait_idle(busy_bad);
    repeat (5) @(negedge clk);
    rand_mode = 1'b0;
    bad = 0;
    for (int b = 0; b < 256 && b < wq.size(); b++) if (wq[b] !== 32'(b)) bad++;
    $display("stream: writes=%0d reads=%0d order_errors=%0d", wq.size(), ar_count, bad);
    check("stream_count", wq.size(), 256);
    check("stream_order", bad, 0);
    check("stream_aw", aw_count, 256);
    check("stream_err_cnt", err_cnt, 8'd2);

    // Reset while in AR
    ar_lat = 20;
    send_byte(8'h77);
    check("pre_rst_ar", axi.m_arvalid, 1'b1);
    pulse_reset();
    check("rst_ar_valids", {axi.m_arvalid, axi.m_awvalid, axi.m_wvalid, axi.m_rready, axi.m_bready}, 5'd0);
    check("rst_ar_busy", busy, 1'b0);
    check("rst_ar_err_cnt", err_cnt, 8'd0);
    @(posedge clk); #2 reset = 1'b0;
    ar_lat = 0;
    $display("reset in AR: busy=%0b err_cnt=%0d", busy, err_cnt);

    // Reset while in AW
    aw_lat = 20; w_lat = 20;
    @(negedge clk);
    send_byte(8'h88);
    n = 0;
    while (!(axi.m_awvalid && axi.m_wvalid) && n < 50) begin @(negedge clk); n++; end
    check("pre_rst_aw", axi.m_awvalid && axi.m_wvalid, 1'b1);
    pulse_reset();
    check("rst_aw_valids", {axi.m_arvalid, axi.m_awvalid, axi.m_wvalid, axi.m_rready, axi.m_bready}, 5'd0);
    check("rst_aw_busy", busy, 1'b0);
    @(posedge clk); #2 reset = 1'b0;
    aw_lat = 0; w_lat = 0;
    $display("reset in AW: busy=%0b err_cnt=%0d", busy, err_cnt);

    @(negedge clk);
    clear_log();
    send_byte(8'h55);
    wait_idle(busy_bad);
    repeat (3) @(negedge clk);
    $display("after reset: byte=55 writes=%0d", wq.size());
    check("post_rst_writes", wq.size(), 1);
    if (wq.size() > 0) check("post_rst_wdata", wq[0], 32'h55);
    check("post_rst_ar", ar_count, 1);

    // err_cnt saturation on repeated DECERR polls
    clear_log();
    rresp_cfg = 2'b11;
    for (int b = 0; b < 256; b++) send_byte(8'(b));
    wait_idle(busy_bad);
    repeat (3) @(negedge clk);
    rresp_cfg = 2'b00;
    $display("saturation: err pulses=%0d err_cnt=%0d", err_seen, err_cnt);
    check("sat_err_cnt", err_cnt, 8'hFF);
    check("sat_err_seen", err_seen, 256);
    check("sat_no_aw", aw_count, 0);

    check("axi_stability", stab_err, 0);
    check("axi_constants", const_err, 0);
    check("err_with_tx_ready", err_ready_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
